// File: rtl/load_store_unit_if.sv
// Pipeline-side and data-memory-side signals of the load/store unit.
// The LSU attaches through the master modport; the pipeline/memory environment uses slave.
interface load_store_unit_if #(
    parameter int width = 32
);
    logic             exValid;
    logic             memRead;
    logic             memWrite;
    logic [2:0]       func3;
    logic [width-1:0] addr;
    logic [width-1:0] storeData;
    logic             stall;
    logic             done;
    logic [width-1:0] loadData;
    logic             memErr;
    logic             dmemReq;
    logic             dmemWe;
    logic [width-1:0] dmemAddr;
    logic [width-1:0] dmemWdata;
    logic [3:0]       dmemBe;
    logic             dmemAck;
    logic [width-1:0] dmemRdata;

    modport master (
        input  exValid, memRead, memWrite, func3, addr, storeData, dmemAck, dmemRdata,
        output stall, done, loadData, memErr, dmemReq, dmemWe, dmemAddr, dmemWdata, dmemBe
    );

    modport slave (
        output exValid, memRead, memWrite, func3, addr, storeData, dmemAck, dmemRdata,
        input  stall, done, loadData, memErr, dmemReq, dmemWe, dmemAddr, dmemWdata, dmemBe
    );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one memory op from execute, issues a single word-aligned
// data-memory request, and returns a sign/zero-extended load result or an error pulse.
module load_store_unit #(
    parameter int width   = 32,
    parameter int TIMEOUT = 255
) (
    input logic               clk,
    input logic               reset,
    load_store_unit_if.master bus
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       lane_q, lane_d;
    logic [2:0]       func3_q, func3_d;
    logic             is_load_q, is_load_d;
    logic             err_q, err_d;
    logic             req_q, req_d;
    logic             we_q, we_d;
    logic [width-1:0] daddr_q, daddr_d;
    logic [width-1:0] wdata_q, wdata_d;
    logic [3:0]       be_q, be_d;
    logic [width-1:0] load_data_q, load_data_d;

    logic             mem_op;
    logic             legal;
    logic             accept_ok;
    logic             accept_bad;
    logic [3:0]       be_in;
    logic [width-1:0] wdata_in;

    // Lane select uses the registered low address bits; H lanes are 0 or 2 only.
    function automatic logic [width-1:0] extract_load(
        input logic [width-1:0] word,
        input logic [1:0]       lane,
        input logic [2:0]       f3
    );
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{lane, 3'b000} +: 8];
        h = word[{lane[1], 4'b0000} +: 16];
        case (f3)
            3'd0:    return {{(width - 8){b[7]}}, b};
            3'd1:    return {{(width - 16){h[15]}}, h};
            3'd4:    return {{(width - 8){1'b0}}, b};
            3'd5:    return {{(width - 16){1'b0}}, h};
            default: return word;
        endcase
    endfunction

    // NOTE: every signal assigned in always_comb gets a default first, so no path infers a latch.
    always_comb begin
        mem_op = bus.exValid & (bus.memRead | bus.memWrite);
        legal  = 1'b0;
        case (bus.func3)
            3'd0:    legal = 1'b1;
            3'd1:    legal = ~bus.addr[0];
            3'd2:    legal = (bus.addr[1:0] == 2'b00);
            3'd4:    legal = bus.memRead;
            3'd5:    legal = bus.memRead & ~bus.addr[0];
            default: legal = 1'b0;
        endcase
        accept_ok  = (state_q == ST_IDLE) & mem_op & legal;
        accept_bad = (state_q == ST_IDLE) & mem_op & ~legal;

        case (bus.func3[1:0])
            2'd0: begin
                be_in    = 4'b0001 << bus.addr[1:0];
                wdata_in = {(width / 8){bus.storeData[7:0]}};
            end
            2'd1: begin
                be_in    = 4'b0011 << bus.addr[1:0];
                wdata_in = {(width / 16){bus.storeData[15:0]}};
            end
            default: begin
                be_in    = 4'b1111;
                wdata_in = bus.storeData;
            end
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        lane_d      = lane_q;
        func3_d     = func3_q;
        is_load_d   = is_load_q;
        err_d       = 1'b0;
        req_d       = req_q;
        we_d        = we_q;
        daddr_d     = daddr_q;
        wdata_d     = wdata_q;
        be_d        = be_q;
        load_data_d = '0;

        case (state_q)
            ST_IDLE: begin
                if (accept_ok) begin
                    state_d   = ST_WAIT;
                    cnt_d     = '0;
                    lane_d    = bus.addr[1:0];
                    func3_d   = bus.func3;
                    is_load_d = bus.memRead;
                    req_d     = 1'b1;
                    we_d      = ~bus.memRead;
                    daddr_d   = {bus.addr[width-1:2], 2'b00};
                    be_d      = be_in;
                    wdata_d   = bus.memRead ? '0 : wdata_in;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (bus.dmemAck || cnt_q == CNT_LAST) begin
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    daddr_d = '0;
                    wdata_d = '0;
                    be_d    = 4'b0000;
                end
                if (bus.dmemAck) begin
                    state_d     = ST_RESP;
                    load_data_d = is_load_q ? extract_load(bus.dmemRdata, lane_q, func3_q) : '0;
                end else if (cnt_q == CNT_LAST) begin
                    // Timeout error is reported in the first IDLE cycle, after the request drops.
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            lane_q      <= 2'b00;
            func3_q     <= 3'd0;
            is_load_q   <= 1'b0;
            err_q       <= 1'b0;
            req_q       <= 1'b0;
            we_q        <= 1'b0;
            daddr_q     <= '0;
            wdata_q     <= '0;
            be_q        <= 4'b0000;
            load_data_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            lane_q      <= lane_d;
            func3_q     <= func3_d;
            is_load_q   <= is_load_d;
            err_q       <= err_d;
            req_q       <= req_d;
            we_q        <= we_d;
            daddr_q     <= daddr_d;
            wdata_q     <= wdata_d;
            be_q        <= be_d;
            load_data_q <= load_data_d;
        end
    end

    assign bus.stall     = accept_ok | (state_q == ST_WAIT);
    assign bus.done      = (state_q == ST_RESP);
    assign bus.memErr    = accept_bad | err_q;
    assign bus.loadData  = load_data_q;
    assign bus.dmemReq   = req_q;
    assign bus.dmemWe    = we_q;
    assign bus.dmemAddr  = daddr_q;
    assign bus.dmemWdata = wdata_q;
    assign bus.dmemBe    = be_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a transaction-level model checks every output each
// cycle, and literal expectations pin the model on the worked examples.
module tb_load_store_unit;
    localparam int TIMEOUT = 255;

    logic clk = 1'b0;
    logic reset;

    load_store_unit_if #(.width(32)) bus ();

    load_store_unit #(.width(32), .TIMEOUT(TIMEOUT)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic bit legal_access(input bit is_load, input logic [2:0] f3, input logic [31:0] a);
        int sz;
        sz = int'(f3[1:0]);
        if (is_load) begin
            if (!(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b0;
        end else if (f3 > 3'd2) begin
            return 1'b0;
        end
        if (sz == 1 && (a % 2) != 0) return 1'b0;
        if (sz == 2 && (a % 4) != 0) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] a);
        int m;
        m = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 3 : 15;
        m = m << (a % 4);
        return m[3:0];
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] d);
        if (f3[1:0] == 2'd0) return (d & 32'hFF) * 32'h0101_0101;
        if (f3[1:0] == 2'd1) return (d & 32'hFFFF) * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] word, input logic [31:0] a,
                                               input logic [2:0] f3);
        logic [31:0] sh;
        logic [31:0] v;
        sh = word >> (8 * (a % 4));
        case (f3)
            3'd0: begin v = sh & 32'hFF;   if (v >= 32'h80)   v = v + 32'hFFFF_FF00; end
            3'd1: begin v = sh & 32'hFFFF; if (v >= 32'h8000) v = v + 32'hFFFF_0000; end
            3'd4: v = sh & 32'hFF;
            3'd5: v = sh & 32'hFFFF;
            default: v = word;
        endcase
        return v;
    endfunction

    bit          m_live = 1'b0;
    bit          m_busy = 1'b0;
    bit          m_resp = 1'b0;
    bit          m_err  = 1'b0;
    int          m_waited = 0;
    logic [31:0] m_addr = '0;
    logic [31:0] m_store = '0;
    logic [2:0]  m_f3 = '0;
    bit          m_load = 1'b0;
    logic [31:0] m_result = '0;

    // Compare on the falling edge with the inputs that the next rising edge will sample.
    always @(negedge clk) begin
        bit acc;
        bit leg;
        bit ld;
        ld  = bus.memRead;
        acc = !m_busy && !m_resp && bus.exValid && (bus.memRead || bus.memWrite);
        leg = legal_access(ld, bus.func3, bus.addr);
        if (m_live) begin
            check_bit("stall", bus.stall, (acc && leg) || m_busy);
            check_bit("memErr", bus.memErr, (acc && !leg) || m_err);
            check_bit("done", bus.done, m_resp);
            check("loadData", bus.loadData, m_resp ? m_result : 32'h0);
            check_bit("dmemReq", bus.dmemReq, m_busy);
            check_bit("dmemWe", bus.dmemWe, m_busy && !m_load);
            check("dmemAddr", bus.dmemAddr, m_busy ? (m_addr & ~32'h3) : 32'h0);
            check("dmemBe", {28'd0, bus.dmemBe}, {28'd0, m_busy ? model_be(m_f3, m_addr) : 4'd0});
            check("dmemWdata", bus.dmemWdata,
                  (m_busy && !m_load) ? model_wdata(m_f3, m_store) : 32'h0);
        end
        if (reset) begin
            m_live   = 1'b1;
            m_busy   = 1'b0;
            m_resp   = 1'b0;
            m_err    = 1'b0;
            m_waited = 0;
            m_result = '0;
        end else begin
            m_err = 1'b0;
            if (m_busy) begin
                if (bus.dmemAck) begin
                    m_busy   = 1'b0;
                    m_resp   = 1'b1;
                    m_result = m_load ? model_load(bus.dmemRdata, m_addr, m_f3) : 32'h0;
                end else if (m_waited + 1 == TIMEOUT) begin
                    m_busy = 1'b0;
                    m_err  = 1'b1;
                end else begin
                    m_waited++;
                end
            end else if (m_resp) begin
                m_resp = 1'b0;
            end else if (acc && leg) begin
                m_busy   = 1'b1;
                m_waited = 0;
                m_addr   = bus.addr;
                m_f3     = bus.func3;
                m_load   = ld;
                m_store  = bus.storeData;
            end
        end
    end

    // ---------------- stimulus ----------------
    typedef struct {
        logic [31:0] load;
        int          stalls;
        bit          done;
        bit          err;
        int          end_cycle;
        bit          req_any;
        bit          req_end;
        logic [31:0] waddr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        we;
    } result_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.exValid   = 1'b0;
        bus.memRead   = 1'b0;
        bus.memWrite  = 1'b0;
        bus.func3     = 3'd0;
        bus.addr      = '0;
        bus.storeData = '0;
        bus.dmemAck   = 1'b0;
        bus.dmemRdata = '0;
    endtask

    // Issues one op; dmemAck is raised only in cycle ack_cycle (cycle 1 = first WAIT cycle).
    task automatic run_access(input logic rd, input logic wr, input logic [2:0] f3,
                              input logic [31:0] a, input logic [31:0] sd,
                              input logic [31:0] rword, input int ack_cycle,
                              input int limit, output result_t r);
        r = '{load: '0, stalls: 0, done: 0, err: 0, end_cycle: -1, req_any: 0, req_end: 0,
              waddr: '0, wdata: '0, be: '0, we: 1'b0};
        bus.exValid   = 1'b1;
        bus.memRead   = rd;
        bus.memWrite  = wr;
        bus.func3     = f3;
        bus.addr      = a;
        bus.storeData = sd;
        for (int c = 0; c <= limit; c++) begin
            if (c > 0) begin
                bus.exValid  = 1'b0;
                bus.memRead  = 1'b0;
                bus.memWrite = 1'b0;
            end
            bus.dmemAck   = (c == ack_cycle);
            bus.dmemRdata = (c == ack_cycle) ? rword : ~rword;
            @(negedge clk);
            if (bus.stall) r.stalls++;
            if (bus.dmemReq) r.req_any = 1'b1;
            if (c == 1) begin
                r.waddr = bus.dmemAddr;
                r.wdata = bus.dmemWdata;
                r.be    = bus.dmemBe;
                r.we    = bus.dmemWe;
            end
            if (bus.done) begin
                r.done = 1'b1;
                r.load = bus.loadData;
            end
            if (bus.memErr) r.err = 1'b1;
            if (r.done || r.err) begin
                r.end_cycle = c;
                r.req_end   = bus.dmemReq;
            end
            tick();
            if (r.done || r.err) break;
        end
        if (!r.done && !r.err) begin
            n_errors++;
            $display("FAIL access_timeout_bound addr %h: no done or memErr within %0d cycles", a, limit);
        end
        idle_inputs();
    endtask

    initial begin
        result_t r;
        reset = 1'b1;
        idle_inputs();
        tick();
        tick();
        @(negedge clk);
        check_bit("reset_stall", bus.stall, 1'b0);
        check_bit("reset_done", bus.done, 1'b0);
        check_bit("reset_memErr", bus.memErr, 1'b0);
        check_bit("reset_dmemReq", bus.dmemReq, 1'b0);
        check("reset_dmemBe", {28'd0, bus.dmemBe}, 32'h0);
        check("reset_loadData", bus.loadData, 32'h0);
        tick();
        reset = 1'b0;

        // Non-memory instruction, memory op without exValid, stray ack in IDLE.
        bus.exValid = 1'b1;
        @(negedge clk);
        check_bit("nonmem_stall", bus.stall, 1'b0);
        tick();
        bus.exValid = 1'b0;
        bus.memRead = 1'b1;
        @(negedge clk);
        check_bit("novalid_stall", bus.stall, 1'b0);
        tick();
        idle_inputs();
        bus.dmemAck   = 1'b1;
        bus.dmemRdata = 32'hFFFF_FFFF;
        tick();
        idle_inputs();
        tick();

        // SB at 0x1002, ack in the second WAIT cycle.
        run_access(1'b0, 1'b1, 3'd0, 32'h1002, 32'h1234_56AB, 32'h0, 2, 10, r);
        check("sb_stalls", 32'(r.stalls), 32'd3);
        check_bit("sb_done", r.done, 1'b1);
        check("sb_addr", r.waddr, 32'h1000);
        check("sb_be", {28'd0, r.be}, 32'h4);
        check("sb_wdata", r.wdata, 32'hABAB_ABAB);
        check_bit("sb_we", r.we, 1'b1);

        run_access(1'b1, 1'b0, 3'd0, 32'h2003, 32'h0, 32'h8011_2233, 1, 10, r);
        check("lb_data", r.load, 32'hFFFF_FF80);
        run_access(1'b1, 1'b0, 3'd4, 32'h2003, 32'h0, 32'h8011_2233, 1, 10, r);
        check("lbu_data", r.load, 32'h0000_0080);
        run_access(1'b1, 1'b0, 3'd5, 32'h2002, 32'h0, 32'h8001_ABCD, 1, 10, r);
        check("lhu_data", r.load, 32'h0000_8001);
        run_access(1'b1, 1'b0, 3'd1, 32'h2002, 32'h0, 32'h8001_ABCD, 3, 10, r);
        check("lh_data", r.load, 32'hFFFF_8001);

        // Illegal / misaligned accesses.
        run_access(1'b1, 1'b0, 3'd2, 32'h2002, 32'h0, 32'h0, 1, 10, r);
        check_bit("lw_mis_err", r.err, 1'b1);
        check("lw_mis_cycle", 32'(r.end_cycle), 32'd0);
        check("lw_mis_stalls", 32'(r.stalls), 32'd0);
        check_bit("lw_mis_req", r.req_any, 1'b0);
        run_access(1'b0, 1'b1, 3'd4, 32'h2000, 32'h55, 32'h0, 1, 10, r);
        check_bit("st_f3_4_err", r.err, 1'b1);
        check_bit("st_f3_4_req", r.req_any, 1'b0);
        run_access(1'b0, 1'b1, 3'd1, 32'h1001, 32'h55, 32'h0, 1, 10, r);
        check_bit("sh_mis_err", r.err, 1'b1);

        // SH upper half, then a load with memRead and memWrite both high.
        run_access(1'b0, 1'b1, 3'd1, 32'h2006, 32'hCAFE_BEEF, 32'h0, 3, 10, r);
        check("sh_be", {28'd0, r.be}, 32'hC);
        check("sh_wdata", r.wdata, 32'hBEEF_BEEF);
        check("sh_addr", r.waddr, 32'h2004);
        run_access(1'b1, 1'b1, 3'd2, 32'h0040, 32'hFFFF_FFFF, 32'h1357_9BDF, 1, 10, r);
        check_bit("rw_we", r.we, 1'b0);
        check("rw_load", r.load, 32'h1357_9BDF);

        // LW with no ack: timeout.
        run_access(1'b1, 1'b0, 3'd2, 32'h3000, 32'h0, 32'h0, -1, TIMEOUT + 5, r);
        check_bit("to_err", r.err, 1'b1);
        check_bit("to_done", r.done, 1'b0);
        check("to_cycle", 32'(r.end_cycle), 32'(TIMEOUT + 1));
        check_bit("to_req_end", r.req_end, 1'b0);
        check("to_stalls", 32'(r.stalls), 32'(TIMEOUT + 1));

        // Reset asserted in the third WAIT cycle, then a stray ack.
        bus.exValid = 1'b1;
        bus.memRead = 1'b1;
        bus.func3   = 3'd2;
        bus.addr    = 32'h3000;
        tick();
        idle_inputs();
        tick();
        tick();
        reset = 1'b1;
        @(negedge clk);
        check_bit("rst3_req_before", bus.dmemReq, 1'b1);
        tick();
        reset         = 1'b0;
        bus.dmemAck   = 1'b1;
        bus.dmemRdata = 32'hDEAD_BEEF;
        @(negedge clk);
        check_bit("rst3_stall", bus.stall, 1'b0);
        check_bit("rst3_done", bus.done, 1'b0);
        check_bit("rst3_memErr", bus.memErr, 1'b0);
        check_bit("rst3_req", bus.dmemReq, 1'b0);
        check_bit("rst3_we", bus.dmemWe, 1'b0);
        check("rst3_addr", bus.dmemAddr, 32'h0);
        check("rst3_wdata", bus.dmemWdata, 32'h0);
        check("rst3_be", {28'd0, bus.dmemBe}, 32'h0);
        check("rst3_load", bus.loadData, 32'h0);
        tick();
        idle_inputs();
        @(negedge clk);
        check_bit("stray_done", bus.done, 1'b0);
        check_bit("stray_memErr", bus.memErr, 1'b0);
        tick();
        tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
